// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate bus between the VGA timing generator and the upstream renderer.
// The timing generator drives the raster position; the renderer returns colour.
`timescale 1ns/1ps
interface vga_timing_gen_if;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic        px_active;
  logic        pix_en;
  logic        frame_start;
  logic        line_start;
  logic [23:0] rgb_in;

  modport master (
    output px_x, px_y, px_active, pix_en, frame_start, line_start,
    input  rgb_in
  );

  modport slave (
    input  px_x, px_y, px_active, pix_en, frame_start, line_start,
    output rgb_in
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing from a 50 MHz clock with a 25 MHz pixel enable.
// Sync/blank are delayed LAT pixel ticks so they line up with the renderer's colour.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int LAT      = 1
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  vga_timing_gen_if.master       pix,
  output logic                   VGA_CLK,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK_N,
  output logic                   VGA_SYNC_N,
  output logic [7:0]             VGA_R,
  output logic [7:0]             VGA_G,
  output logic [7:0]             VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic [23:0] gateColour(input logic en, input logic [23:0] colour);
    return en ? colour : 24'h000000;
  endfunction

  logic           pixEn;
  logic           vgaClk;
  logic           running;
  logic [9:0]     hCnt;
  logic [9:0]     vCnt;
  logic           hWrap;
  logic           vWrap;
  logic           hsRaw;
  logic           vsRaw;
  logic           actRaw;
  logic           actNext;
  logic [LAT-1:0] hsPipe;
  logic [LAT-1:0] vsPipe;
  logic [LAT-1:0] actPipe;
  logic [23:0]    rgbReg;

  // Pixel enable and DAC clock; VGA_CLK rises one cycle after the pixel edge.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pixEn   <= 1'b0;
      vgaClk  <= 1'b0;
      running <= 1'b0;
    end else begin
      pixEn   <= ~pixEn;
      vgaClk  <= ~pixEn;
      running <= 1'b1;
    end
  end

  assign hWrap = (hCnt == H_LAST);
  assign vWrap = (vCnt == V_LAST);

  // Stage 0: raster counters, wrapping on compare.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (pixEn) begin
      if (hWrap) begin
        hCnt <= '0;
        vCnt <= vWrap ? '0 : vCnt + 10'd1;
      end else begin
        hCnt <= hCnt + 10'd1;
      end
    end
  end

  assign hsRaw  = !((hCnt >= HS_BEG) && (hCnt < HS_END));
  assign vsRaw  = !((vCnt >= VS_BEG) && (vCnt < VS_END));
  // running keeps px_active low while held in reset even though the counters read (0,0).
  assign actRaw = running && (hCnt < H_ACT_END) && (vCnt < V_ACT_END);

  // The colour arriving now belongs to the pixel about to enter the last delay stage.
  if (LAT == 1) begin : gNext
    assign actNext = actRaw;
  end else begin : gNext
    assign actNext = actPipe[LAT-2];
  end

  // Stages 1..LAT: sync/blank delay line and registered colour.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hsPipe  <= '1;
      vsPipe  <= '1;
      actPipe <= '0;
      rgbReg  <= '0;
    end else if (pixEn) begin
      hsPipe[0]  <= hsRaw;
      vsPipe[0]  <= vsRaw;
      actPipe[0] <= actRaw;
      for (int i = 1; i < LAT; i++) begin
        hsPipe[i]  <= hsPipe[i-1];
        vsPipe[i]  <= vsPipe[i-1];
        actPipe[i] <= actPipe[i-1];
      end
      rgbReg <= gateColour(actNext, pix.rgb_in);
    end
  end

  assign pix.px_x        = hCnt;
  assign pix.px_y        = vCnt;
  assign pix.px_active   = actRaw;
  assign pix.pix_en      = pixEn;
  assign pix.line_start  = pixEn && (hCnt == 10'd0);
  assign pix.frame_start = pixEn && (hCnt == 10'd0) && (vCnt == 10'd0);

  assign VGA_CLK     = vgaClk;
  assign VGA_HS      = hsPipe[LAT-1];
  assign VGA_VS      = vsPipe[LAT-1];
  assign VGA_BLANK_N = actPipe[LAT-1];
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = rgbReg[23:16];
  assign VGA_G       = rgbReg[15:8];
  assign VGA_B       = rgbReg[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster so whole frames fit in a short run.
// Expected outputs come from a cycle-index model of the raster arithmetic.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int HA = 64, HF = 8, HSW = 12, HB = 6;
  localparam int VA = 20, VF = 3, VSW = 2, VB = 5;
  localparam int LATP = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam logic [52:0] RST_VEC = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b1, 1'b1, 1'b0, 1'b0, 24'd0};

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b1;
  logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  int          colourMode = 0;
  logic [23:0] key        = 24'h0;
  logic [23:0] rgbQ[$];

  vga_timing_gen_if pif();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .LAT(LATP)
  ) u_dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .pix        (pif),
    .VGA_CLK    (VGA_CLK),
    .VGA_HS     (VGA_HS),
    .VGA_VS     (VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N (VGA_SYNC_N),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] colourOf(input int x, input int y);
    logic [9:0] xx;
    logic [9:0] yy;
    xx = 10'(x);
    yy = 10'(y);
    case (colourMode)
      0:       return 24'hFFFFFF;
      1:       return {xx[7:0], yy[7:0], 8'h5A};
      default: return {xx[7:0] ^ key[7:0], yy[7:0] ^ key[15:8], key[23:16]};
    endcase
  endfunction

  // Renderer: total latency LATP pixel ticks, i.e. LATP-1 ticks of its own before the DUT register.
  always @(negedge CLOCK_50) begin
    if (!RESET_N) begin
      rgbQ.delete();
      pif.rgb_in = 24'h0;
    end else if (pif.pix_en) begin
      rgbQ.push_back(colourOf(int'(pif.px_x), int'(pif.px_y)));
      if (rgbQ.size() >= LATP) pif.rgb_in = rgbQ.pop_front();
    end
  end

  // Expected outputs during clock cycle c after reset release (c=1 follows the first edge).
  function automatic logic [52:0] expectVec(input int c);
    int idx, o, h, v, oh, ov;
    logic pe, act, hs, vs, bl;
    logic [23:0] rgb;
    idx = c / 2;
    pe  = (c % 2) == 1;
    h   = idx % HT;
    v   = (idx / HT) % VT;
    act = (h < HA) && (v < VA);
    o   = idx - LATP;
    hs = 1'b1; vs = 1'b1; bl = 1'b0; rgb = 24'h0;
    if (o >= 0) begin
      oh  = o % HT;
      ov  = (o / HT) % VT;
      hs  = !((oh >= HA + HF) && (oh < HA + HF + HSW));
      vs  = !((ov >= VA + VF) && (ov < VA + VF + VSW));
      bl  = (oh < HA) && (ov < VA);
      rgb = bl ? colourOf(oh, ov) : 24'h0;
    end
    return {10'(h), 10'(v), act, pe, pe && h == 0 && v == 0, pe && h == 0, pe,
            hs, vs, bl, 1'b0, rgb};
  endfunction

  function automatic logic [52:0] obsVec();
    return {pif.px_x, pif.px_y, pif.px_active, pif.pix_en, pif.frame_start, pif.line_start,
            VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B};
  endfunction

  task automatic stepCycle();
    @(posedge CLOCK_50);
    cyc++;
    @(negedge CLOCK_50);
  endtask

  task automatic restart();
    RESET_N = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    #7 RESET_N = 1'b0;
    #1;
    compared++;
    if (obsVec() !== RST_VEC) begin
      mismatched++;
      $display("FAIL reset_async got=%h want=%h", obsVec(), RST_VEC);
    end
    repeat (2) @(negedge CLOCK_50);
    compared++;
    if (obsVec() !== RST_VEC) begin
      mismatched++;
      $display("FAIL reset_held got=%h want=%h", obsVec(), RST_VEC);
    end
    RESET_N = 1'b1;
    cyc = 0;
    for (int n = 0; n < 6; n++) begin
      stepCycle();
      compared++;
      if (obsVec() !== expectVec(cyc)) begin
        mismatched++;
        $display("FAIL reset_release cyc=%0d got=%h want=%h", cyc, obsVec(), expectVec(cyc));
      end
    end
  endtask

  task automatic test_raster();
    int hsFall, vsFall, hsLow, vsLow, ffCnt, blankRgb, ls1, ls2, fs1, fs2, bad;
    logic prevHs, prevVs, win;
    hsFall = -1; vsFall = -1; hsLow = 0; vsLow = 0; ffCnt = 0; blankRgb = 0;
    ls1 = -1; ls2 = -1; fs1 = -1; fs2 = -1; bad = 0; prevHs = 1'b1; prevVs = 1'b1;
    colourMode = 0;
    restart();
    for (int n = 0; n < 2 * HT * VT + 8; n++) begin
      stepCycle();
      compared++;
      if (obsVec() !== expectVec(cyc)) begin
        mismatched++; bad++;
        $display("FAIL raster cyc=%0d got=%h want=%h", cyc, obsVec(), expectVec(cyc));
        if (bad > 8) break;
      end
      if (prevHs && !VGA_HS && hsFall < 0) hsFall = cyc;
      if (prevVs && !VGA_VS && vsFall < 0) vsFall = cyc;
      if (cyc >= 2 * LATP && cyc < 2 * LATP + 2 * HT && !VGA_HS) hsLow++;
      win = (cyc >= 2 * LATP) && (cyc < 2 * LATP + 2 * HT * VT);
      if (win && !VGA_VS) vsLow++;
      if (win && VGA_BLANK_N && VGA_R == 8'hFF) ffCnt++;
      if (!VGA_BLANK_N && {VGA_R, VGA_G, VGA_B} != 24'h0) blankRgb++;
      if (pif.line_start) begin
        if (ls1 < 0) ls1 = cyc; else if (ls2 < 0) ls2 = cyc;
      end
      if (pif.frame_start) begin
        if (fs1 < 0) fs1 = cyc; else if (fs2 < 0) fs2 = cyc;
      end
      prevHs = VGA_HS;
      prevVs = VGA_VS;
    end
    compared++;
    if (hsFall !== 2 * (HA + HF + LATP)) begin
      mismatched++; $display("FAIL hs_fall_cycle got=%0d want=%0d", hsFall, 2 * (HA + HF + LATP));
    end
    compared++;
    if (hsLow !== 2 * HSW) begin
      mismatched++; $display("FAIL hs_low_width got=%0d want=%0d", hsLow, 2 * HSW);
    end
    compared++;
    if (ls2 - ls1 !== 2 * HT) begin
      mismatched++; $display("FAIL line_period got=%0d want=%0d", ls2 - ls1, 2 * HT);
    end
    compared++;
    if (vsFall !== 2 * (HT * (VA + VF) + LATP)) begin
      mismatched++; $display("FAIL vs_fall_cycle got=%0d want=%0d", vsFall, 2 * (HT * (VA + VF) + LATP));
    end
    compared++;
    if (vsLow !== 2 * HT * VSW) begin
      mismatched++; $display("FAIL vs_low_width got=%0d want=%0d", vsLow, 2 * HT * VSW);
    end
    compared++;
    if (fs2 - fs1 !== 2 * HT * VT) begin
      mismatched++; $display("FAIL frame_period got=%0d want=%0d", fs2 - fs1, 2 * HT * VT);
    end
    compared++;
    if (ffCnt !== 2 * HA * VA) begin
      mismatched++; $display("FAIL white_pixels got=%0d want=%0d", ffCnt, 2 * HA * VA);
    end
    compared++;
    if (blankRgb !== 0) begin
      mismatched++; $display("FAIL rgb_in_blank got=%0d want=0", blankRgb);
    end
  endtask

  task automatic test_pattern();
    int bad, rise, fall;
    bad = 0;
    rise = 2 * (10 * HT + LATP);
    fall = 2 * (10 * HT + HA + LATP);
    colourMode = 1;
    restart();
    for (int n = 0; n < 2 * 12 * HT; n++) begin
      stepCycle();
      compared++;
      if (obsVec() !== expectVec(cyc)) begin
        mismatched++; bad++;
        $display("FAIL pattern cyc=%0d got=%h want=%h", cyc, obsVec(), expectVec(cyc));
        if (bad > 8) break;
      end
      if (cyc == rise - 1) begin
        compared++;
        if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== {1'b0, 24'h000000}) begin
          mismatched++; $display("FAIL line10_pre got=%h want=%h", {VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, {1'b0, 24'h000000});
        end
      end
      if (cyc == rise) begin
        compared++;
        if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'h000A5A}) begin
          mismatched++; $display("FAIL line10_first got=%h want=%h", {VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, {1'b1, 24'h000A5A});
        end
      end
      if (cyc == fall - 1) begin
        compared++;
        if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== {1'b1, 8'h3F, 8'h0A, 8'h5A}) begin
          mismatched++; $display("FAIL line10_last got=%h want=%h", {VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, {1'b1, 8'h3F, 8'h0A, 8'h5A});
        end
      end
      if (cyc == fall) begin
        compared++;
        if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== {1'b0, 24'h000000}) begin
          mismatched++; $display("FAIL line10_blank got=%h want=%h", {VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, {1'b0, 24'h000000});
        end
      end
    end
  endtask

  task automatic test_wrap();
    int bad;
    bad = 0;
    colourMode = 0;
    restart();
    for (int n = 0; n < 2 * HT * VT + 4; n++) begin
      stepCycle();
      compared++;
      if (obsVec() !== expectVec(cyc)) begin
        mismatched++; bad++;
        $display("FAIL wrap_run cyc=%0d got=%h want=%h", cyc, obsVec(), expectVec(cyc));
        if (bad > 8) break;
      end
      if (cyc == 22 * HT - 1) begin
        compared++;
        if ({pif.px_x, pif.px_y, pif.line_start} !== {10'(HT - 1), 10'd10, 1'b0}) begin
          mismatched++; $display("FAIL wrap_line_end got=%h want=%h", {pif.px_x, pif.px_y, pif.line_start}, {10'(HT - 1), 10'd10, 1'b0});
        end
      end
      if (cyc == 22 * HT + 1) begin
        compared++;
        if ({pif.px_x, pif.px_y, pif.line_start, pif.frame_start} !== {10'd0, 10'd11, 1'b1, 1'b0}) begin
          mismatched++; $display("FAIL wrap_line_next got=%h want=%h", {pif.px_x, pif.px_y, pif.line_start, pif.frame_start}, {10'd0, 10'd11, 1'b1, 1'b0});
        end
      end
      if (cyc == 2 * HT * VT - 1) begin
        compared++;
        if ({pif.px_x, pif.px_y} !== {10'(HT - 1), 10'(VT - 1)}) begin
          mismatched++; $display("FAIL wrap_frame_end got=%h want=%h", {pif.px_x, pif.px_y}, {10'(HT - 1), 10'(VT - 1)});
        end
      end
      if (cyc == 2 * HT * VT + 1) begin
        compared++;
        if ({pif.px_x, pif.px_y, pif.line_start, pif.frame_start} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
          mismatched++; $display("FAIL wrap_frame_next got=%h want=%h", {pif.px_x, pif.px_y, pif.line_start, pif.frame_start}, {10'd0, 10'd0, 1'b1, 1'b1});
        end
      end
    end
  endtask

  task automatic test_midframe_reset();
    int bad, target;
    bad = 0;
    colourMode = 2;
    key = 24'($urandom);
    restart();
    for (int k = 0; k < 4; k++) begin
      target = (k == 0) ? (12 * HT + 30) : int'($urandom_range(HT * VT - 1, 0));
      for (int n = 0; n < 2 * HT * VT + 4; n++) begin
        if (cyc == 2 * target + 1) break;
        stepCycle();
        compared++;
        if (obsVec() !== expectVec(cyc)) begin
          mismatched++; bad++;
          $display("FAIL midrun cyc=%0d got=%h want=%h", cyc, obsVec(), expectVec(cyc));
          if (bad > 8) break;
        end
      end
      compared++;
      if ({pif.px_x, pif.px_y} !== {10'(target % HT), 10'(target / HT)}) begin
        mismatched++; $display("FAIL mid_position got=%h want=%h", {pif.px_x, pif.px_y}, {10'(target % HT), 10'(target / HT)});
      end
      #3 RESET_N = 1'b0;
      #1;
      compared++;
      if (obsVec() !== RST_VEC) begin
        mismatched++; $display("FAIL mid_reset_now got=%h want=%h", obsVec(), RST_VEC);
      end
      repeat (3) begin
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        compared++;
        if (obsVec() !== RST_VEC) begin
          mismatched++; $display("FAIL mid_reset_hold got=%h want=%h", obsVec(), RST_VEC);
        end
      end
      key = 24'($urandom);
      RESET_N = 1'b1;
      cyc = 0;
      stepCycle();
      compared++;
      if ({pif.px_x, pif.px_y, pif.frame_start, pif.pix_en} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
        mismatched++; $display("FAIL mid_restart got=%h want=%h", {pif.px_x, pif.px_y, pif.frame_start, pif.pix_en}, {10'd0, 10'd0, 1'b1, 1'b1});
      end
      compared++;
      if (obsVec() !== expectVec(cyc)) begin
        mismatched++; $display("FAIL mid_restart_vec got=%h want=%h", obsVec(), expectVec(cyc));
      end
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_pattern();
    test_wrap();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
